// File: rtl/gpio_led_driver_if.sv
// Bundles the GPIO mode word and the four LED drives between the AXI GPIO
// output channel (master side) and the LED driver (slave side).
interface gpio_led_driver_if;
  logic [7:0] gpio;
  logic       led_0;
  logic       led_1;
  logic       led_2;
  logic       led_3;

  modport master (
    output gpio,
    input  led_0,
    input  led_1,
    input  led_2,
    input  led_3
  );

  modport slave (
    input  gpio,
    output led_0,
    output led_1,
    output led_2,
    output led_3
  );
endinterface

// File: rtl/gpio_led_driver.sv
// Four-LED driver: each LED takes a 2-bit mode (off / on / slow blink /
// fast blink) from the GPIO word. Blink timing is generated locally with an
// independent half-period counter per LED. A mode change restarts the blink
// phase lit; rewriting the same mode leaves the phase untouched.
module gpio_led_driver #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int SLOW_HZ     = 1,
  parameter int FAST_HZ     = 4
) (
  input  logic             clk,
  input  logic             srst,
  gpio_led_driver_if.slave bus
);

  localparam int HALF_SLOW = CLK_FREQ_HZ / (2 * SLOW_HZ);
  localparam int HALF_FAST = CLK_FREQ_HZ / (2 * FAST_HZ);
  localparam int CW        = (HALF_SLOW <= 2) ? 1 : $clog2(HALF_SLOW);

  // Terminal counts are compared at full counter width, so a non power of
  // two half-period never wraps early.
  localparam logic [CW-1:0] SLOW_TC = CW'(HALF_SLOW - 1);
  localparam logic [CW-1:0] FAST_TC = CW'(HALF_FAST - 1);

  if (HALF_SLOW < 2) begin : g_chk_slow
    $error("gpio_led_driver: HALF_SLOW must be >= 2");
  end
  if (HALF_FAST < 2) begin : g_chk_fast
    $error("gpio_led_driver: HALF_FAST must be >= 2");
  end
  // The counter is sized for the slow half-period; fast must fit inside it.
  if (HALF_FAST > HALF_SLOW) begin : g_chk_order
    $error("gpio_led_driver: HALF_FAST must not exceed HALF_SLOW");
  end

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ON   = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  mode_e         mode_q [4];
  mode_e         mode_d [4];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_n  [4];
  logic [3:0]    led_q;
  logic [3:0]    led_n;

  // Next counter/LED value per channel from the registered mode.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_n[i] = '0;
      led_n[i] = 1'b0;
      case (mode_q[i])
        MODE_OFF: begin
          led_n[i] = 1'b0;
        end
        MODE_ON: begin
          led_n[i] = 1'b1;
        end
        default: begin
          if (mode_q[i] != mode_d[i]) begin
            led_n[i] = 1'b1;
          end else if (cnt_q[i] == ((mode_q[i] == MODE_FAST) ? FAST_TC : SLOW_TC)) begin
            led_n[i] = ~led_q[i];
          end else begin
            led_n[i] = led_q[i];
            cnt_n[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
    end
  end

  // Mode capture, change-detect history, counters and LED output registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 4; i++) begin
        mode_q[i] <= MODE_OFF;
        mode_d[i] <= MODE_OFF;
        cnt_q[i]  <= '0;
      end
      led_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mode_q[i] <= mode_e'(bus.gpio[2*i +: 2]);
        mode_d[i] <= mode_q[i];
        cnt_q[i]  <= cnt_n[i];
      end
      led_q <= led_n;
    end
  end

  assign bus.led_0 = led_q[0];
  assign bus.led_1 = led_q[1];
  assign bus.led_2 = led_q[2];
  assign bus.led_3 = led_q[3];

endmodule

// File: tb/tb_gpio_led_driver.sv
// Bench for gpio_led_driver: directed vectors with literal spot checks, plus
// a period-arithmetic model compared against the LEDs on every cycle.
module tb_gpio_led_driver;

  localparam int CLK_HZ = 100;
  localparam int SLOW   = 5;
  localparam int FAST   = 25;
  localparam int HS     = CLK_HZ / (2 * SLOW);
  localparam int HF     = CLK_HZ / (2 * FAST);

  logic clk  = 1'b0;
  logic srst = 1'b1;

  gpio_led_driver_if bus ();

  gpio_led_driver #(
    .CLK_FREQ_HZ(CLK_HZ),
    .SLOW_HZ    (SLOW),
    .FAST_HZ    (FAST)
  ) dut (
    .clk (clk),
    .srst(srst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] led_v;
  assign led_v = {bus.led_3, bus.led_2, bus.led_1, bus.led_0};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a blink that started at edge st is lit during the even
  // H-long windows counted from st.
  int         mq [4];
  int         md [4];
  int         st [4];
  logic [3:0] exp_led = '0;

  initial begin
    int n;
    int h;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; md[i] = 0; st[i] = 0;
    end
    forever begin
      @(posedge clk);
      n++;
      if (srst) begin
        exp_led = '0;
        for (int i = 0; i < 4; i++) begin
          mq[i] = 0; md[i] = 0;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (mq[i] == 0) exp_led[i] = 1'b0;
          else if (mq[i] == 1) exp_led[i] = 1'b1;
          else begin
            h = (mq[i] == 2) ? HS : HF;
            if (mq[i] != md[i]) st[i] = n;
            exp_led[i] = (((n - st[i]) / h) % 2) == 0;
          end
          md[i] = mq[i];
          mq[i] = int'(bus.gpio[2*i +: 2]);
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model", int'(led_v), int'(exp_led));
    end
  end

  initial begin
    int hi;
    bus.gpio = 8'hFF;
    srst     = 1'b1;

    // Reset held three cycles with all fields in fast blink.
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("reset_hold", int'(led_v), 0);
    end
    srst = 1'b0;
    tick(1);
    chk("release_edge1", int'(led_v), 0);
    tick(1);
    chk("release_edge2", int'(led_v), 4'hF);

    // Steady on / off.
    bus.gpio = 8'h00;
    tick(2);
    chk("all_off", int'(led_v), 0);
    bus.gpio = 8'h55;
    tick(2);
    chk("all_on", int'(led_v), 4'hF);
    bus.gpio = 8'h54;
    tick(1);
    chk("led0_off_lat1", int'(led_v), 4'hF);
    tick(1);
    chk("led0_off_lat2", int'(led_v), 4'hE);

    // Slow blink on LED0 for five periods.
    bus.gpio = 8'h02;
    for (int t = 1; t <= 101; t++) begin
      tick(1);
      if (t == 2)   chk("slow_t2",   int'(led_v), 4'h1);
      if (t == 11)  chk("slow_t11",  int'(led_v), 4'h1);
      if (t == 12)  chk("slow_t12",  int'(led_v), 4'h0);
      if (t == 21)  chk("slow_t21",  int'(led_v), 4'h0);
      if (t == 22)  chk("slow_t22",  int'(led_v), 4'h1);
      if (t == 101) chk("slow_t101", int'(led_v), 4'h0);
    end

    // Fast blink, then switch to slow during a high phase.
    bus.gpio = 8'h03;
    for (int s = 1; s <= 18; s++) begin
      tick(1);
      if (s == 2)  chk("fast_s2",  int'(led_v), 4'h1);
      if (s == 4)  chk("fast_s4",  int'(led_v), 4'h0);
      if (s == 6)  chk("fast_s6",  int'(led_v), 4'h1);
      if (s == 7)  chk("sw_s7",    int'(led_v), 4'h1);
      if (s == 8)  chk("sw_s8",    int'(led_v), 4'h1);
      if (s == 17) chk("sw_s17",   int'(led_v), 4'h1);
      if (s == 18) chk("sw_s18",   int'(led_v), 4'h0);
      if (s == 6)  bus.gpio = 8'h02;
    end

    // Slow blink on LED2 with the same word rewritten every cycle.
    bus.gpio = 8'h20;
    hi = 0;
    for (int t = 1; t <= 31; t++) begin
      tick(1);
      bus.gpio = 8'h20;
      if (t >= 2 && led_v[2]) hi++;
      if (t == 11) chk("rewr_t11", int'(led_v), 4'h4);
      if (t == 12) chk("rewr_t12", int'(led_v), 4'h0);
      if (t == 22) chk("rewr_t22", int'(led_v), 4'h4);
      if (t == 31) chk("rewr_t31", int'(led_v), 4'h4);
    end
    chk("rewr_high_count", hi, 20);

    // Reset in the middle of a low phase, gpio left unchanged.
    bus.gpio = 8'h02;
    for (int t = 1; t <= 30; t++) begin
      tick(1);
      if (t == 11) chk("rst_t11", int'(led_v), 4'h1);
      if (t == 16) chk("rst_t16", int'(led_v), 4'h0);
      if (t == 17) chk("rst_t17", int'(led_v), 4'h0);
      if (t == 19) chk("rst_t19", int'(led_v), 4'h0);
      if (t == 20) chk("rst_t20", int'(led_v), 4'h1);
      if (t == 29) chk("rst_t29", int'(led_v), 4'h1);
      if (t == 30) chk("rst_t30", int'(led_v), 4'h0);
      if (t == 16) srst = 1'b1;
      if (t == 18) srst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
